// File: rtl/mma_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mma_timer_pkg
//  Description : Shared definitions for the countdown timer: FSM state
//                encoding and the prescaler counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mma_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      DONE    = 2'd2
   } timer_state_t;

   // One extra bit beyond $clog2 keeps the width >= 1 when the prescaler is 1.
   function automatic int pcnt_width(input int prescaler);
      return $clog2(prescaler) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Counts enabled cycles and emits a tick on every PRESCALER-th
//                enabled cycle, wrapping its counter to zero on that cycle.
//  Revision    : 1.0  initial release
//  Ports       : clk     - module clock
//                reset_n - asynchronous active-low reset
//                clear   - synchronous counter clear (wins over en)
//                en      - advance the counter this cycle
//                tick    - high on the enabled cycle where the counter wraps
// ============================================================================
module timer_prescaler
   import mma_timer_pkg::*;
#(
   parameter int PRESCALER = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int                   PCNT_WIDTH  = pcnt_width(PRESCALER);
   localparam logic [PCNT_WIDTH-1:0] c_pcnt_last = PCNT_WIDTH'(PRESCALER - 1);

   logic [PCNT_WIDTH-1:0] r_pcnt;

   assign tick = en && !clear && (r_pcnt == c_pcnt_last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pcnt <= '0;
      end else if (clear) begin
         r_pcnt <= '0;
      end else if (en) begin
         if (r_pcnt == c_pcnt_last) begin
            r_pcnt <= '0;
         end else begin
            r_pcnt <= r_pcnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable countdown timer with prescaler, one-shot or
//                periodic auto-reload, pause (en) and abort.
//  Revision    : 1.0  initial release
//  Ports       : clk, reset_n            - clock, async active-low reset
//                load_valid/load_value   - load request and count value
//                load_ready              - load accepted when high (not RUNNING)
//                periodic                - auto-reload, captured with the load
//                start                   - begin countdown (IDLE only)
//                en                      - count enable while RUNNING
//                abort                   - clear count, return to IDLE
//                count                   - remaining count
//                busy                    - high while RUNNING
//                expired                 - one-cycle pulse after terminal tick
// ============================================================================
module countdown_timer
   import mma_timer_pkg::*;
#(
   parameter int PRESCALER   = 1,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   load_valid,
   input  logic [COUNT_WIDTH-1:0] load_value,
   output logic                   load_ready,
   input  logic                   periodic,
   input  logic                   start,
   input  logic                   en,
   input  logic                   abort,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   busy,
   output logic                   expired
);

   localparam logic [COUNT_WIDTH-1:0] c_count_one = COUNT_WIDTH'(1);

   timer_state_t           r_state;
   logic [COUNT_WIDTH-1:0] r_count;
   logic [COUNT_WIDTH-1:0] r_reload;
   logic                   r_periodic;
   logic                   r_expired;

   logic w_load_acc;
   logic w_tick;

   // Ready/busy are pure state decodes, so they follow reset immediately.
   assign load_ready = (r_state != RUNNING);
   assign busy       = (r_state == RUNNING);
   assign count      = r_count;
   assign expired    = r_expired;

   assign w_load_acc = load_valid && load_ready;

   // A load or abort restarts the prescaler phase from zero.
   timer_prescaler #(
      .PRESCALER (PRESCALER)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (abort || w_load_acc),
      .en      ((r_state == RUNNING) && en),
      .tick    (w_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_reload   <= '0;
         r_periodic <= 1'b0;
         r_expired  <= 1'b0;
      end else begin
         r_expired <= 1'b0;
         if (abort) begin
            // Abort outranks load, start and a coincident terminal tick.
            r_state <= IDLE;
            r_count <= '0;
         end else begin
            case (r_state)
               IDLE, DONE: begin
                  if (w_load_acc) begin
                     r_count    <= load_value;
                     r_reload   <= load_value;
                     r_periodic <= periodic;
                     r_state    <= (load_value == '0) ? DONE : IDLE;
                  end else if ((r_state == IDLE) && start && (r_count != '0)) begin
                     r_state <= RUNNING;
                  end
               end
               RUNNING: begin
                  if (w_tick) begin
                     // <= 1 rather than == 1 so the count can never wrap.
                     if (r_count <= c_count_one) begin
                        r_expired <= 1'b1;
                        if (r_periodic) begin
                           r_count <= r_reload;
                        end else begin
                           r_count <= '0;
                           r_state <= DONE;
                        end
                     end else begin
                        r_count <= r_count - c_count_one;
                     end
                  end
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer (PRESCALER=4,
//                COUNT_WIDTH=8) against a tick-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

   localparam int P  = 4;
   localparam int CW = 8;

   localparam int PH_IDLE = 0;
   localparam int PH_RUN  = 1;
   localparam int PH_DONE = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          load_valid;
   logic [CW-1:0] load_value;
   logic          load_ready;
   logic          periodic;
   logic          start;
   logic          en;
   logic          abort;
   logic [CW-1:0] count;
   logic          busy;
   logic          expired;

   int n_tests  = 0;
   int n_failed = 0;

   // Reference model: count derived from enabled cycles since start.
   int m_phase;
   int m_n;
   int m_per;
   int m_en_cyc;
   int m_count;
   int m_exp;

   always #5 clk = ~clk;

   countdown_timer #(
      .PRESCALER   (P),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_value (load_value),
      .load_ready (load_ready),
      .periodic   (periodic),
      .start      (start),
      .en         (en),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .expired    (expired)
   );

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase  = PH_IDLE;
      m_n      = 0;
      m_per    = 0;
      m_en_cyc = 0;
      m_count  = 0;
      m_exp    = 0;
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic model_step();
      int ticks;
      m_exp = 0;
      if (abort) begin
         m_phase = PH_IDLE;
         m_count = 0;
      end else if (m_phase != PH_RUN) begin
         if (load_valid) begin
            m_n     = int'(load_value);
            m_per   = int'(periodic);
            m_count = m_n;
            m_phase = (m_n == 0) ? PH_DONE : PH_IDLE;
         end else if (m_phase == PH_IDLE && start && m_count != 0) begin
            m_phase  = PH_RUN;
            m_en_cyc = 0;
         end
      end else if (en) begin
         m_en_cyc++;
         if (m_en_cyc % P == 0) begin
            ticks = m_en_cyc / P;
            if (m_per != 0) begin
               m_count = m_n - (ticks % m_n);
               if (ticks % m_n == 0) m_exp = 1;
            end else begin
               m_count = m_n - ticks;
               if (ticks == m_n) begin
                  m_exp   = 1;
                  m_phase = PH_DONE;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      check("count",      int'(count),      m_count);
      check("busy",       int'(busy),       (m_phase == PH_RUN) ? 1 : 0);
      check("load_ready", int'(load_ready), (m_phase != PH_RUN) ? 1 : 0);
      check("expired",    int'(expired),    m_exp);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      load_valid = 1'b0;
      load_value = '0;
      periodic   = 1'b0;
      start      = 1'b0;
      en         = 1'b0;
      abort      = 1'b0;
   endtask

   task automatic do_load(input int v, input int per);
      load_valid = 1'b1;
      load_value = CW'(v);
      periodic   = per[0];
      step();
      load_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Steps until expired is seen; returns the edge index, 0 on timeout.
   task automatic wait_expired(input int budget, output int n);
      n = 0;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (expired) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   // Reset pulsed between clock edges; outputs must clear without an edge.
   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int lat;
      idle_inputs();
      model_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      reset_n = 1'b1;
      step();

      // One-shot load 3: count steps every 4 edges, expiry at edge 12.
      do_load(3, 0);
      en = 1'b1;
      do_start();
      wait_expired(40, lat);
      check("latency_oneshot", lat, 12);
      check("busy_done", int'(busy), 0);
      step();

      // Periodic load 2: expiry every 8 cycles while staying busy.
      do_load(2, 1);
      do_start();
      for (int k = 0; k < 3; k++) begin
         wait_expired(40, lat);
         check("period_gap", lat, 8);
         check("count_reload", int'(count), 2);
         check("busy_periodic", int'(busy), 1);
      end
      do_abort();

      // Pause for 5 cycles mid-count delays the expiry by 5.
      do_load(3, 0);
      do_start();
      repeat (5) step();
      en = 1'b0;
      repeat (5) step();
      en = 1'b1;
      wait_expired(40, lat);
      check("latency_paused", lat + 10, 17);
      step();

      // Abort on the terminal tick suppresses expired.
      do_load(1, 0);
      do_start();
      repeat (3) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_count", int'(count), 0);
      step();
      check("abort_no_exp", int'(expired), 0);

      // Load of zero goes straight to DONE; start is then ignored.
      do_load(0, 0);
      check("zero_ready", int'(load_ready), 1);
      do_start();
      check("zero_not_busy", int'(busy), 0);
      repeat (3) step();

      // Asynchronous reset mid-count.
      do_load(5, 0);
      do_start();
      repeat (6) step();
      async_reset();
      repeat (30) step();

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         load_valid = ($urandom_range(0, 99) < 10);
         load_value = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 20))
                                                  : CW'($urandom_range(0, 4));
         periodic   = $urandom_range(0, 1) == 1;
         start      = ($urandom_range(0, 99) < 20);
         en         = ($urandom_range(0, 99) < 80);
         abort      = ($urandom_range(0, 99) < 2);
         step();
         if ($urandom_range(0, 499) == 0) begin
            idle_inputs();
            async_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter PRESCALER, default 1: enabled clock cycles per count decrement; legal values are 1 and above.
REQ-002 Parameter COUNT_WIDTH, default 32: width of the count and load registers.
REQ-003 clk  input  1  module clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 load_valid  input  1  load request; qualifies load_value.
REQ-006 load_value  input  COUNT_WIDTH  initial and reload count.
REQ-007 load_ready  output  1  high when a load can be accepted.
REQ-008 periodic  input  1  auto-reload mode; sampled with the accepted load.
REQ-009 start  input  1  begin countdown; sampled in IDLE only.
REQ-010 en  input  1  count enable while RUNNING; low freezes the prescaler and count.
REQ-011 abort  input  1  cancel the countdown and clear the count.
REQ-012 count  output  COUNT_WIDTH  current remaining count.
REQ-013 busy  output  1  high while in RUNNING.
REQ-014 expired  output  1  registered single-cycle pulse on terminal count.

Function
REQ-015 FSM states SHALL be IDLE, RUNNING and DONE; each output SHALL be registered or decoded from state only.
REQ-016 load_ready SHALL be 1 in IDLE and DONE, and 0 in RUNNING.
REQ-017 A load is accepted when load_valid and load_ready are both 1; acceptance sets count=load_value, reload_reg=load_value, periodic_reg=periodic, pcnt=0, and state=IDLE.
REQ-018 A load with load_value=0 SHALL be accepted; the state then goes to DONE on the same edge, with no expired pulse.
REQ-019 In IDLE, start=1 with count!=0 SHALL move the state to RUNNING on that edge; start with count=0 SHALL be ignored.
REQ-020 In RUNNING with en=1, pcnt SHALL increment; on the cycle where pcnt==PRESCALER-1 (the tick), pcnt SHALL become 0 and count SHALL decrement by 1.
REQ-021 In RUNNING with en=0, pcnt and count SHALL hold.
REQ-022 On a tick with count==1 and periodic_reg=0: count SHALL become 0, the state SHALL go to DONE, and expired SHALL be high for exactly the following cycle.
REQ-023 On a tick with count==1 and periodic_reg=1: count SHALL become reload_reg, the state SHALL stay RUNNING, and expired SHALL pulse as in REQ-022.
REQ-024 abort=1 in any state SHALL set count=0, pcnt=0, and state=IDLE on that edge.
REQ-025 abort SHALL take priority over load, start and tick in the same cycle; when abort coincides with a terminal tick, no expired pulse is produced.
REQ-026 A load and a start in the same cycle in IDLE: the load SHALL take effect and the start SHALL be ignored.
REQ-027 In DONE, start SHALL be ignored; a new load is required to restart.
REQ-028 Arithmetic is unsigned at COUNT_WIDTH; count SHALL never underflow below 0.
REQ-029 Latency: with en held high, expired SHALL rise N*PRESCALER cycles after the edge that samples start, where N=load_value.

Reset
REQ-030 On reset_n=0, asynchronously: state=IDLE, count=0, pcnt=0, reload_reg=0, periodic_reg=0, expired=0, busy=0, load_ready=1.
REQ-031 Reset deasserted mid-countdown SHALL leave the block in IDLE with no expired pulse.

Structure
REQ-032 Package mma_timer_pkg SHALL hold the FSM state encoding (IDLE, RUNNING, DONE) and a PCNT_WIDTH helper, $clog2(PRESCALER)+1.
REQ-033 Sub-module timer_prescaler SHALL be used, with inputs clk, reset_n, clear and en, and output tick, holding pcnt.

Verification (PRESCALER=4, COUNT_WIDTH=8)
REQ-034 Load 3 with periodic=0, start, en=1 -> count steps 3,2,1,0 at edges 4, 8 and 12 after start; expired is high for one cycle after edge 12; state is DONE with busy=0.
REQ-035 Load 2 with periodic=1, en=1 -> expired pulses every 8 cycles, count reloads to 2 each time, busy stays 1.
REQ-036 Load 3, start, en low for 5 cycles mid-count -> the expired pulse is delayed by exactly 5 cycles.
REQ-037 abort asserted on the terminal tick cycle -> no expired pulse; count=0, state IDLE.
REQ-038 Load 0 -> state DONE with no expired pulse; a following start is ignored; load_ready=1.
REQ-039 reset_n pulsed low mid-count asynchronously (between edges) -> all outputs go to their reset values immediately, and no expired pulse follows.
